// File: rtl/dlf_pkg.sv
// -----------------------------------------------------------------------------
// dlf_pkg
// Shared types and constants for the dlf_pi_lock loop filter:
//   CODE_W  - width of the control code sent to the dithering converter
//   FRAC    - fraction bits carried by the integrator
//   INTEG_W - signed integrator width
//   dlf_state_t - gear state (ACQ / TRK / LOCKED)
//   pd_t        - signed phase-detector decision (-1, 0, +1)
// Optional lock detector is selected with the DLF_LOCK_DET_EN macro.
// -----------------------------------------------------------------------------
package dlf_pkg;

    localparam int CODE_W   = 13;
    localparam int FRAC     = 8;
    localparam int INTEG_W  = 22;
    localparam int CODE_MAX = (1 << CODE_W) - 1;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRK    = 2'd1,
        LOCKED = 2'd2
    } dlf_state_t;

    typedef logic signed [1:0] pd_t;

    // Contradictory or absent detector decisions carry no phase information.
    function automatic pd_t pd_decode(input logic up, input logic dn);
        if (up && !dn)      return pd_t'(1);
        else if (dn && !up) return pd_t'(-1);
        else                return pd_t'(0);
    endfunction

endpackage

// File: rtl/dlf_pi_lock_if.sv
// -----------------------------------------------------------------------------
// dlf_pi_lock_if
// Bundles the loop-filter datapath signals.
//   en     - update enable (master -> slave)
//   up     - phase detector "early" (master -> slave)
//   dn     - phase detector "late" (master -> slave)
//   out    - CODE_W-bit unsigned control code (slave -> master)
//   locked - lock indicator (slave -> master)
// -----------------------------------------------------------------------------
interface dlf_pi_lock_if;
    import dlf_pkg::*;

    logic              en;
    logic              up;
    logic              dn;
    logic [CODE_W-1:0] out;
    logic              locked;

    modport master (output en, output up, output dn, input out, input locked);
    modport slave  (input en, input up, input dn, output out, output locked);

endinterface

// File: rtl/dlf_lock_det.sv
// -----------------------------------------------------------------------------
// dlf_lock_det
// Lock-quality observer for the PI loop filter. Counts phase-error sign
// reversals over fixed windows and tracks the length of same-sign runs.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - advance enable; all state holds when low
//   pd        - current phase decision
//   restart   - clear window and reversal count (re-acquisition)
//   win_done  - pulse: this cycle closes a window
//   win_ok    - pulse: closing window had >= LOCK_MIN reversals
//   run_hit   - pulse: same-sign run has reached UNLOCK_RUN
// Only built when DLF_LOCK_DET_EN is defined.
// -----------------------------------------------------------------------------
module dlf_lock_det
    import dlf_pkg::*;
#(
    parameter int LOCK_WIN   = 64,
    parameter int LOCK_MIN   = 16,
    parameter int UNLOCK_RUN = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  pd_t  pd,
    input  logic restart,
    output logic win_done,
    output logic win_ok,
    output logic run_hit
);

    localparam int WIN_W = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
    localparam int REV_W = $clog2(LOCK_WIN + 1);
    localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

    logic [WIN_W-1:0] win_cnt;
    logic [REV_W-1:0] rev_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nx;
    logic             last_valid;
    logic             last_neg;
    logic             nz;
    logic             pd_neg;
    logic             rev_now;

    assign nz      = (pd != pd_t'(0));
    assign pd_neg  = pd[1];
    assign rev_now = en && nz && last_valid && (pd_neg != last_neg);

    // Run length saturates at the limit; zero decisions leave it untouched.
    always_comb begin
        run_nx = run_cnt;
        if (nz) begin
            if (last_valid && (pd_neg == last_neg)) begin
                if (int'(run_cnt) < UNLOCK_RUN)
                    run_nx = run_cnt + RUN_W'(1);
            end else begin
                run_nx = RUN_W'(1);
            end
        end
    end

    // The closing window includes the reversal seen on its last cycle.
    assign win_done = en && (int'(win_cnt) == LOCK_WIN - 1);
    assign win_ok   = win_done && ((int'(rev_cnt) + (rev_now ? 1 : 0)) >= LOCK_MIN);
    assign run_hit  = en && nz && (int'(run_nx) >= UNLOCK_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            rev_cnt    <= '0;
            run_cnt    <= '0;
            last_valid <= 1'b0;
            last_neg   <= 1'b0;
        end else if (en) begin
            run_cnt <= run_nx;
            if (nz) begin
                last_valid <= 1'b1;
                last_neg   <= pd_neg;
            end
            if (restart || win_done) begin
                win_cnt <= '0;
                rev_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                rev_cnt <= rev_cnt + {{(REV_W-1){1'b0}}, rev_now};
            end
        end
    end

endmodule

// File: rtl/dlf_pi_lock.sv
// -----------------------------------------------------------------------------
// dlf_pi_lock
// Gear-shifted proportional-integral loop filter. Converts bang-bang phase
// decisions into a saturated unsigned control code for the MASH converter.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset (beats en)
//   bus   - dlf_pi_lock_if.slave: en, up, dn in; out, locked out
// Configuration macro DLF_LOCK_DET_EN:
//   defined   - lock detector + ACQ/TRK/LOCKED gear FSM
//   undefined - fixed TRK gains, locked tied low
// -----------------------------------------------------------------------------
module dlf_pi_lock
    import dlf_pkg::*;
#(
    parameter int INIT_CODE  = 4096,
    parameter int KP_ACQ     = 64,
    parameter int KP_TRK     = 8,
    parameter int KI_SH_ACQ  = 8,
    parameter int KI_SH_TRK  = 4,
    parameter int LOCK_WIN   = 64,
    parameter int LOCK_MIN   = 16,
    parameter int UNLOCK_RUN = 32
) (
    input logic         clk,
    input logic         rst,
    dlf_pi_lock_if.slave bus
);

    // Integrator limits keep INIT_CODE + integ inside the code range.
    localparam int INTEG_LO = -(INIT_CODE * (1 << FRAC));
    localparam int INTEG_HI = (CODE_MAX - INIT_CODE) * (1 << FRAC);

    pd_t                       pd;
    dlf_state_t                state;
    logic                      locked_q;
    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] integ_nx;
    logic [CODE_W-1:0]         out_q;
    logic [CODE_W-1:0]         out_nx;
    int                        kp;
    int                        ki_sh;
    int                        isum;
    int                        iclamp;
    int                        osum;

    assign pd = pd_decode(bus.up, bus.dn);

    // Gains follow the registered state, so a gear shift applies one edge later.
    always_comb begin
        kp     = (state == ACQ) ? KP_ACQ    : KP_TRK;
        ki_sh  = (state == ACQ) ? KI_SH_ACQ : KI_SH_TRK;
        isum   = int'(integ) + (int'(pd) <<< ki_sh);
        iclamp = isum;
        if (isum < INTEG_LO)      iclamp = INTEG_LO;
        else if (isum > INTEG_HI) iclamp = INTEG_HI;
        integ_nx = INTEG_W'(iclamp);
        // Arithmetic shift floors toward minus infinity.
        osum   = INIT_CODE + int'(integ_nx >>> FRAC) + kp * int'(pd);
        out_nx = out_q;
        if (osum < 0)             out_nx = '0;
        else if (osum > CODE_MAX) out_nx = CODE_W'(CODE_MAX);
        else                      out_nx = CODE_W'(osum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ <= '0;
            out_q <= CODE_W'(INIT_CODE);
        end else if (bus.en) begin
            integ <= integ_nx;
            out_q <= out_nx;
        end
    end

`ifdef DLF_LOCK_DET_EN
    logic win_done;
    logic win_ok;
    logic run_hit;
    logic restart;

    assign restart = bus.en && (state == LOCKED) && run_hit;

    dlf_lock_det #(
        .LOCK_WIN   (LOCK_WIN),
        .LOCK_MIN   (LOCK_MIN),
        .UNLOCK_RUN (UNLOCK_RUN)
    ) u_lock_det (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .pd       (pd),
        .restart  (restart),
        .win_done (win_done),
        .win_ok   (win_ok),
        .run_hit  (run_hit)
    );

    // Window ends are ignored in LOCKED, so a coinciding run limit always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQ;
            locked_q <= 1'b0;
        end else if (bus.en) begin
            case (state)
                ACQ: begin
                    if (win_ok) state <= TRK;
                end
                TRK: begin
                    if (win_done) begin
                        state    <= win_ok ? LOCKED : ACQ;
                        locked_q <= win_ok;
                    end
                end
                LOCKED: begin
                    if (run_hit) begin
                        state    <= ACQ;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ACQ;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end
`else
    assign state    = TRK;
    assign locked_q = 1'b0;
`endif

    assign bus.out    = out_q;
    assign bus.locked = locked_q;

endmodule

// File: tb/tb_dlf_pi_lock.sv
// -----------------------------------------------------------------------------
// tb_dlf_pi_lock
// Directed self-checking bench for dlf_pi_lock. dut_a uses default
// parameters, dut_b uses INIT_CODE=8180 to exercise upper saturation.
// Expectations follow the DLF_LOCK_DET_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_dlf_pi_lock;
    import dlf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dlf_pi_lock_if bus_a ();
    dlf_pi_lock_if bus_b ();

    dlf_pi_lock dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dlf_pi_lock #(.INIT_CODE(8180)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Drive dut_a for one clock, then settle 1 time unit past the edge.
    task automatic cycle_a(input logic en, input logic up, input logic dn);
        bus_a.en = en;
        bus_a.up = up;
        bus_a.dn = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(input logic en, input logic up, input logic dn);
        bus_b.en = en;
        bus_b.up = up;
        bus_b.dn = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle_a(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_b.en = 1'b1;
        bus_b.up = 1'b1;
        bus_b.dn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle_a(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus_a.out !== 13'd4096) begin
                errors++;
                $display("[TB] FAIL reset_out cycle %0d: got %0d expected 4096", i, bus_a.out);
            end
            checks++;
            if (bus_a.locked !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_locked cycle %0d: got %0b expected 0", i, bus_a.locked);
            end
            checks++;
            if (bus_b.out !== 13'd8180) begin
                errors++;
                $display("[TB] FAIL reset_out_b cycle %0d: got %0d expected 8180", i, bus_b.out);
            end
        end
        rst = 1'b0;
        bus_b.en = 1'b0;
        bus_b.up = 1'b0;
        cycle_a(1'b0, 1'b0, 1'b0);
    endtask

`ifdef DLF_LOCK_DET_EN
    task automatic test_acq_ramp();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle_a(1'b1, 1'b1, 1'b0);
            if (i == 1) begin
                checks++;
                if (bus_a.out !== 13'd4161) begin
                    errors++;
                    $display("[TB] FAIL acq_first: got %0d expected 4161", bus_a.out);
                end
            end
        end
        checks++;
        if (bus_a.out !== 13'd4170) begin
            errors++;
            $display("[TB] FAIL acq_tenth: got %0d expected 4170", bus_a.out);
        end
        cycle_a(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4106) begin
            errors++;
            $display("[TB] FAIL acq_idle: got %0d expected 4106", bus_a.out);
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 20; i++) begin
            cycle_b(1'b1, 1'b1, 1'b0);
            if (i == 1 || i == 20) begin
                checks++;
                if (bus_b.out !== 13'd8191) begin
                    errors++;
                    $display("[TB] FAIL sat_high cycle %0d: got %0d expected 8191", i, bus_b.out);
                end
            end
        end
        cycle_b(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus_b.out !== 13'd8126) begin
            errors++;
            $display("[TB] FAIL sat_release: got %0d expected 8126", bus_b.out);
        end
        cycle_b(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i <= 128; i++) begin
            cycle_a(1'b1, i[0], !i[0]);
            if (i == 64) begin
                checks++;
                if (bus_a.out !== 13'd4032) begin
                    errors++;
                    $display("[TB] FAIL lock_acq_out: got %0d expected 4032", bus_a.out);
                end
            end
            if (i == 65) begin
                checks++;
                if (bus_a.out !== 13'd4104) begin
                    errors++;
                    $display("[TB] FAIL lock_trk_gain: got %0d expected 4104", bus_a.out);
                end
            end
            if (i == 127) begin
                checks++;
                if (bus_a.locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lock_early: got %0b expected 0", bus_a.locked);
                end
            end
        end
        checks++;
        if (bus_a.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_assert: got %0b expected 1", bus_a.locked);
        end
        for (int j = 1; j <= 32; j++) begin
            cycle_a(1'b1, 1'b1, 1'b0);
            if (j == 31) begin
                checks++;
                if (bus_a.locked !== 1'b1 || bus_a.out !== 13'd4105) begin
                    errors++;
                    $display("[TB] FAIL run_31: got locked=%0b out=%0d expected 1/4105", bus_a.locked, bus_a.out);
                end
            end
        end
        checks++;
        if (bus_a.locked !== 1'b0 || bus_a.out !== 13'd4106) begin
            errors++;
            $display("[TB] FAIL unlock: got locked=%0b out=%0d expected 0/4106", bus_a.locked, bus_a.out);
        end
        cycle_a(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4163) begin
            errors++;
            $display("[TB] FAIL reacq_gain: got %0d expected 4163", bus_a.out);
        end
    endtask

    task automatic test_en_pause();
        do_reset();
        for (int i = 1; i <= 30; i++) cycle_a(1'b1, i[0], !i[0]);
        for (int p = 1; p <= 10; p++) begin
            cycle_a(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus_a.out !== 13'd4032 || bus_a.locked !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pause_hold %0d: got out=%0d locked=%0b expected 4032/0", p, bus_a.out, bus_a.locked);
            end
        end
        for (int i = 31; i <= 128; i++) begin
            cycle_a(1'b1, i[0], !i[0]);
            if (i == 65) begin
                checks++;
                if (bus_a.out !== 13'd4104) begin
                    errors++;
                    $display("[TB] FAIL pause_trk_gain: got %0d expected 4104", bus_a.out);
                end
            end
            if (i == 127) begin
                checks++;
                if (bus_a.locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pause_lock_early: got %0b expected 0", bus_a.locked);
                end
            end
        end
        checks++;
        if (bus_a.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_lock: got %0b expected 1", bus_a.locked);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        cycle_a(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if (bus_a.out !== 13'd4096 || bus_a.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got out=%0d locked=%0b expected 4096/0", bus_a.out, bus_a.locked);
        end
        cycle_a(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4161) begin
            errors++;
            $display("[TB] FAIL post_reset_acq: got %0d expected 4161", bus_a.out);
        end
    endtask
`else
    task automatic test_trk_step();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cycle_a(1'b1, 1'b1, 1'b0);
            if (i == 1 || i == 15) begin
                checks++;
                if (bus_a.out !== 13'd4104) begin
                    errors++;
                    $display("[TB] FAIL trk_step cycle %0d: got %0d expected 4104", i, bus_a.out);
                end
            end
        end
        checks++;
        if (bus_a.out !== 13'd4105) begin
            errors++;
            $display("[TB] FAIL trk_carry: got %0d expected 4105", bus_a.out);
        end
        cycle_a(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4097) begin
            errors++;
            $display("[TB] FAIL trk_idle: got %0d expected 4097", bus_a.out);
        end
        cycle_a(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus_a.out !== 13'd4088 || bus_a.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL trk_dn: got out=%0d locked=%0b expected 4088/0", bus_a.out, bus_a.locked);
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 200; i++) begin
            cycle_b(1'b1, 1'b1, 1'b0);
            if (i == 1) begin
                checks++;
                if (bus_b.out !== 13'd8188) begin
                    errors++;
                    $display("[TB] FAIL sat_first: got %0d expected 8188", bus_b.out);
                end
            end
        end
        checks++;
        if (bus_b.out !== 13'd8191) begin
            errors++;
            $display("[TB] FAIL sat_high: got %0d expected 8191", bus_b.out);
        end
        cycle_b(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus_b.out !== 13'd8182) begin
            errors++;
            $display("[TB] FAIL sat_release: got %0d expected 8182", bus_b.out);
        end
        cycle_b(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_no_lock();
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            cycle_a(1'b1, i[0], !i[0]);
            checks++;
            if (bus_a.locked !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_lock cycle %0d: got %0b expected 0", i, bus_a.locked);
            end
            if (i == 1 || i == 2 || i == 256) begin
                checks++;
                if (bus_a.out !== (i[0] ? 13'd4104 : 13'd4088)) begin
                    errors++;
                    $display("[TB] FAIL no_lock_out cycle %0d: got %0d expected %0d", i, bus_a.out, i[0] ? 4104 : 4088);
                end
            end
        end
    endtask

    task automatic test_en_pause();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle_a(1'b1, 1'b1, 1'b0);
        for (int p = 1; p <= 10; p++) begin
            cycle_a(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus_a.out !== 13'd4104) begin
                errors++;
                $display("[TB] FAIL pause_hold %0d: got %0d expected 4104", p, bus_a.out);
            end
        end
        cycle_a(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4104) begin
            errors++;
            $display("[TB] FAIL pause_resume: got %0d expected 4104", bus_a.out);
        end
        for (int i = 7; i <= 16; i++) cycle_a(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4105) begin
            errors++;
            $display("[TB] FAIL pause_carry: got %0d expected 4105", bus_a.out);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        cycle_a(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if (bus_a.out !== 13'd4096 || bus_a.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got out=%0d locked=%0b expected 4096/0", bus_a.out, bus_a.locked);
        end
        cycle_a(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_a.out !== 13'd4104) begin
            errors++;
            $display("[TB] FAIL post_reset_trk: got %0d expected 4104", bus_a.out);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        bus_a.en = 1'b0;
        bus_a.up = 1'b0;
        bus_a.dn = 1'b0;
        bus_b.en = 1'b0;
        bus_b.up = 1'b0;
        bus_b.dn = 1'b0;
        test_reset();
        test_saturation();
`ifdef DLF_LOCK_DET_EN
        test_acq_ramp();
        test_lock();
        test_en_pause();
`else
        test_trk_step();
        test_no_lock();
        test_en_pause();
`endif
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
